sram_req_bridge: RTL and testbench

//  Initiator side of the single-port SRAM interface (addr/ce/we/be/dataw/datar,
//  1-cycle registered read data). Accepts valid/ready byte-addressed requests from
//  a fabric or cache port, drives the SRAM port, and returns in-order responses on
//  a valid/ready channel through a response FIFO, so the core tolerates response backpressure.

---
 rtl/sram_req_bridge_pkg.sv | 19 +
 rtl/sram_rsp_fifo.sv | 58 +++++
 rtl/sram_req_bridge.sv | 101 ++++++++++
 tb/tb_sram_req_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_bridge_pkg.sv
// Shared sizing helpers for the SRAM request bridge: response entry width and
// byte-to-word address conversion widths.
package sram_req_bridge_pkg;

  localparam int BRG_FLAG_W = 2;

  function automatic int brg_rsp_w(input int data_width);
    return data_width + BRG_FLAG_W;
  endfunction

  function automatic int brg_byte_sh(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int brg_sram_aw(input int data_depth);
    return $clog2(data_depth);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; simultaneous push and pop is legal at any fill level.
module sram_rsp_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_MAX);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/sram_req_bridge.sv
// Initiator for a single-port SRAM with 1-cycle read latency: issues requests,
// buffers in-order responses in a FIFO, and grants credit only when a slot is free.
module sram_req_bridge
  import sram_req_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [DATA_WIDTH/8-1:0]       req_be,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          sram_ce,
  output logic                          sram_we,
  output logic [$clog2(DATA_DEPTH)-1:0] sram_addr,
  output logic [DATA_WIDTH/8-1:0]       sram_be,
  output logic [DATA_WIDTH-1:0]         sram_dataw,
  input  logic [DATA_WIDTH-1:0]         sram_datar
);

  localparam int RSP_W   = brg_rsp_w(DATA_WIDTH);
  localparam int BYTE_SH = brg_byte_sh(DATA_WIDTH);
  localparam int SRAM_AW = brg_sram_aw(DATA_DEPTH);
  localparam int CW      = $clog2(RSP_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] w_widx;
  logic                  w_oor;
  logic                  w_accept;
  logic [CW-1:0]         w_outstanding;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [RSP_W-1:0]      w_push_entry;
  logic [RSP_W-1:0]      w_head;
  logic [DATA_WIDTH-1:0] w_rdata_p1;
  logic                  w_pop;

  logic                  r_pend_p1;
  logic                  r_write_p1;
  logic                  r_err_p1;

  // Stage 0: credit check and combinational SRAM issue
  assign w_widx        = req_addr >> BYTE_SH;
  assign w_oor         = (w_widx >= ADDR_WIDTH'(DATA_DEPTH));
  assign w_outstanding = CW'(r_pend_p1) + w_fifo_count;
  assign req_ready     = rst_n & ~w_fifo_full & (w_outstanding < CW'(RSP_DEPTH));
  assign w_accept      = req_valid & req_ready;

  assign sram_ce    = w_accept & ~w_oor;
  assign sram_we    = req_write;
  assign sram_addr  = w_widx[SRAM_AW-1:0];
  assign sram_be    = req_write ? req_be : '0;
  assign sram_dataw = req_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend_p1 <= 1'b0;
    else        r_pend_p1 <= w_accept;
  end

  always_ff @(posedge clk) begin
    r_write_p1 <= req_write;
    r_err_p1   <= w_oor;
  end

  // Stage 1: SRAM read data is valid now; build the entry and push unconditionally
  assign w_rdata_p1   = (!r_write_p1 && !r_err_p1) ? sram_datar : '0;
  assign w_push_entry = {r_write_p1, r_err_p1, w_rdata_p1};
  assign w_pop        = rsp_valid & rsp_ready;

  sram_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pend_p1),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign rsp_valid = ~w_fifo_empty;
  assign rsp_write = w_head[RSP_W-1];
  assign rsp_err   = w_head[RSP_W-2];
  assign rsp_rdata = w_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_req_bridge.sv
// Bench for sram_req_bridge: SRAM model, in-order scoreboard with shadow memory,
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_sram_req_bridge;

  localparam int DW = 64;
  localparam int DD = 1024;
  localparam int AW = 32;
  localparam int RD = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          sram_ce, sram_we;
  logic [9:0]    sram_addr;
  logic [BW-1:0] sram_be;
  logic [DW-1:0] sram_dataw, sram_datar;

  always #5 clk = ~clk;

  sram_req_bridge #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_be    (sram_be),
    .sram_dataw (sram_dataw),
    .sram_datar (sram_datar)
  );

  // SRAM model: write lands at the issue edge, read data registered one cycle later
  logic [DW-1:0] ram [DD];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) ram[sram_addr][b*8 +: 8] <= sram_dataw[b*8 +: 8];
      end else begin
        sram_datar <= ram[sram_addr];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request owes one response, in acceptance order,
  // visible two cycles after acceptance; read data comes from a shadow of memory.
  typedef struct {
    logic          w;
    logic          e;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] shadow [DD];

  always @(negedge clk) begin
    exp_t          ex;
    exp_t          got;
    logic [AW-1:0] widx;
    logic          oor;
    logic          exp_vld;
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("req_ready_credit", req_ready, q.size() < RD);
      exp_vld = 1'b0;
      if (q.size() > 0) exp_vld = (q[0].cyc <= cyc - 2);
      chk("rsp_valid_timing", rsp_valid, exp_vld);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          got = q.pop_front();
          chk("rsp_write", rsp_write, got.w);
          chk("rsp_err", rsp_err, got.e);
          chk("rsp_rdata", rsp_rdata, got.d);
        end
      end
      if (req_valid && req_ready) begin
        widx = req_addr / BW;
        oor  = (widx >= DD);
        chk("sram_ce_issue", sram_ce, !oor);
        if (!oor) begin
          chk("sram_addr", sram_addr, widx);
          chk("sram_we", sram_we, req_write);
          chk("sram_be", sram_be, req_write ? req_be : '0);
          if (req_write) chk("sram_dataw", sram_dataw, req_wdata);
        end
        if (req_write && !oor)
          for (int b = 0; b < BW; b++)
            if (req_be[b]) shadow[widx][b*8 +: 8] = req_wdata[b*8 +: 8];
        ex.w   = req_write;
        ex.e   = oor;
        ex.d   = (req_write || oor) ? '0 : shadow[widx];
        ex.cyc = cyc;
        q.push_back(ex);
      end else begin
        chk("sram_ce_idle", sram_ce, 1'b0);
      end
    end
  end

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    logic          ew;
    logic          ee;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vt[12];

  // Single request with rsp_ready held; checks acceptance, SRAM enable, 2-cycle latency
  task automatic do_req(input vec_t v);
    int n;
    int lat;
    req_valid = 1'b1; req_write = v.w; req_addr = v.a; req_wdata = v.d; req_be = v.be;
    rsp_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("vec_accept", req_ready, 1'b1);
    chk("vec_ce", sram_ce, !v.ee);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("vec_latency", lat, 2);
    chk("vec_rsp_write", rsp_write, v.ew);
    chk("vec_rsp_err", rsp_err, v.ee);
    chk("vec_rsp_rdata", rsp_rdata, v.ed);
    @(posedge clk); #1;
  endtask

  task automatic tick(output logic acc);
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   issued;
    int   n;
    int   r;

    for (int i = 0; i < DD; i++) begin ram[i] = '0; shadow[i] = '0; end
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    #2 rst_n = 1'b0;

    vt[0]  = '{1'b1, 32'h40,   64'h1122334455667788, 8'hFF, 1'b1, 1'b0, 64'h0};
    vt[1]  = '{1'b0, 32'h40,   64'h0,                8'h00, 1'b0, 1'b0, 64'h1122334455667788};
    vt[2]  = '{1'b1, 32'h48,   64'h1111111111111111, 8'hFF, 1'b1, 1'b0, 64'h0};
    vt[3]  = '{1'b1, 32'h48,   64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1, 1'b0, 64'h0};
    vt[4]  = '{1'b0, 32'h48,   64'h0,                8'hFF, 1'b0, 1'b0, 64'h11111111AAAAAAAA};
    vt[5]  = '{1'b0, 32'h2000, 64'h0,                8'h00, 1'b0, 1'b1, 64'h0};
    vt[6]  = '{1'b0, 32'h40,   64'h0,                8'h00, 1'b0, 1'b0, 64'h1122334455667788};
    vt[7]  = '{1'b1, 32'h2008, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1, 1'b1, 64'h0};
    vt[8]  = '{1'b1, 32'h50,   64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 1'b0, 64'h0};
    vt[9]  = '{1'b0, 32'h50,   64'h0,                8'h00, 1'b0, 1'b0, 64'h0};
    vt[10] = '{1'b0, 32'h45,   64'h0,                8'h00, 1'b0, 1'b0, 64'h1122334455667788};
    vt[11] = '{1'b0, 32'h1FF8, 64'h0,                8'h00, 1'b0, 1'b0, 64'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_sram_ce", sram_ce, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_req(vt[i]);

    // Back-to-back reads with the response channel always ready
    rsp_ready = 1'b1;
    issued = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i * 8);
      @(negedge clk);
      chk("b2b_ready", req_ready, 1'b1);
      if (req_valid && req_ready) issued++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_accepted", issued, 16);
    repeat (4) tick(acc);
    chk("b2b_drained", q.size(), 0);

    // Response backpressure: only RSP_DEPTH requests may be outstanding
    rsp_ready = 1'b0;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (issued < 6); req_write = 1'b0; req_addr = AW'((issued + 1) * 8);
      tick(acc);
      if (acc) issued++;
    end
    chk("bp_accepted", issued, 4);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    while (issued < 6 && n < 20) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'((issued + 1) * 8);
      tick(acc);
      if (acc) issued++;
      n++;
    end
    req_valid = 1'b0;
    chk("bp_remaining", issued, 6);
    repeat (6) tick(acc);
    chk("bp_drained", q.size(), 0);

    // Reset with three buffered responses and one pending
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i * 8);
      tick(acc);
    end
    chk("rst_pre_buffered", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_sram_ce", sram_ce, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("rst_release_ready", req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_replay", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Random traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 19);
      req_valid = ($urandom_range(0, 9) < 7);
      req_write = $urandom_range(0, 1);
      req_addr  = AW'(((r < 16) ? r : (1006 + r)) * 8 + $urandom_range(0, 7));
      req_wdata = {$urandom, $urandom};
      req_be    = BW'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick(acc);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) tick(acc);
    chk("rand_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
